operand_stack: RTL and testbench
================================

OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of stack entries (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous empty-stack request.
REQ-006 op_valid  input  1  qualifies sp_op for this cycle.
REQ-007 sp_op  input  2  stack op: 00 DES_2, 01 DES_1, 10 ADV_0, 11 ADV_1.
REQ-008 wr_en  input  1  write wr_data into the post-op top entry.
REQ-009 wr_data  input  WIDTH  data written by push/replace.
REQ-010 top  output  WIDTH  top-of-stack value.
REQ-011 second  output  WIDTH  second-of-stack value.
REQ-012 count  output  clog2(DEPTH+1)  number of valid entries.
REQ-013 full, empty  output  1 each  count==DEPTH, count==0.
REQ-014 err  output  1  sticky illegal-op flag.
REQ-015 err_code  output  2  first error cause: 01 overflow, 10 underflow, 00 none.

Function
REQ-016 Storage: DEPTH x WIDTH register array plus count register; entry count-1 is top.
REQ-017 top = mem[count-1] when count>=1, else 0; second = mem[count-2] when count>=2, else 0; both combinational from registered state.
REQ-018 ADV_1: legal if count<DEPTH; count+1; mem[count] <= wr_data (wr_en ignored, push always writes).
REQ-019 ADV_0: count unchanged; if wr_en, mem[count-1] <= wr_data; legal if count>=1 when wr_en, always legal otherwise.
REQ-020 DES_1: count-1; if wr_en, mem[count-2] <= wr_data (binary-op result); legal if count>=1 (no wr_en) or count>=2 (wr_en).
REQ-021 DES_2: count-2; wr_en ignored; legal if count>=2.
REQ-022 op_valid=0: no state change regardless of sp_op/wr_en.
REQ-023 Latency: effect of an op visible on top/second/count/full/empty one cycle after the accepting edge; back-to-back ops every cycle supported.
REQ-024 Illegal op (overflow on ADV_1 when full; underflow per REQ-019..021): no change to count or mem.
REQ-025 clear=1: count <= 0 next edge, overrides op_valid; mem contents not required to be zeroed.
REQ-026 No wrap-around: count never exceeds DEPTH nor goes below 0.

Reset
REQ-027 rst_n low: immediately count=0, empty=1, full=0, top=0, second=0, err=0, err_code=00, independent of clk.
REQ-028 rst_n low mid-operation: in-flight op discarded; first op accepted on first rising edge after rst_n deasserts.
REQ-029 Memory array contents need not be reset.

Configuration
REQ-030 Macro OPERAND_STACK_GUARD_EN defined: illegal op sets err=1 and, if err was 0, latches err_code; err/err_code hold until rst_n or clear.
REQ-031 OPERAND_STACK_GUARD_EN undefined: illegal ops still suppressed per REQ-024; err and err_code tied to 0; no error registers synthesised.
REQ-032 Simultaneous clear and illegal op with guard enabled: clear wins, err stays/returns 0.

Verification
REQ-033 Reset, push 0x11,0x22,0x33 (ADV_1) -> count=3, top=0x33, second=0x22, empty=0.
REQ-034 With 0x05,0x07 stacked, DES_1 wr_en=1 wr_data=0x0C -> next cycle count=1, top=0x0C, second=0.
REQ-035 Fill DEPTH=16 entries, ADV_1 once more with 0xFF -> full=1, count=16, top unchanged; guard on: err=1, err_code=01.
REQ-036 count=1, DES_2 -> count stays 1, top unchanged; guard on: err=1, err_code=10; guard off: err=0.
REQ-037 count=4, assert clear with op_valid=1 ADV_1 same cycle -> count=0, empty=1, err=0.
REQ-038 Assert rst_n low between edges during a push stream -> outputs per REQ-027 immediately, no push lands after release.

Source files
------------

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - Register-based operand stack with push/replace/pop-1/pop-2 ops
//
// Optional feature: define OPERAND_STACK_GUARD_EN to build the sticky err/err_code
// registers; without it illegal ops are still suppressed but err/err_code read 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   clear     in   synchronous empty-stack request, overrides op_valid
//   op_valid  in   qualifies sp_op this cycle
//   sp_op     in   00 DES_2, 01 DES_1, 10 ADV_0, 11 ADV_1
//   wr_en     in   write wr_data into the post-op top entry
//   wr_data   in   data for push/replace
//   top       out  mem[count-1] or 0
//   second    out  mem[count-2] or 0
//   count     out  number of valid entries
//   full      out  count == DEPTH
//   empty     out  count == 0
//   err       out  sticky illegal-op flag
//   err_code  out  first error cause: 01 overflow, 10 underflow
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       op_valid,
  input  logic [1:0]                 sp_op,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           second,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TWO     = CW'(2);

  localparam logic [1:0] OP_DES_2 = 2'b00;
  localparam logic [1:0] OP_DES_1 = 2'b01;
  localparam logic [1:0] OP_ADV_0 = 2'b10;
  localparam logic [1:0] OP_ADV_1 = 2'b11;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic [CW-1:0] op_count;
  logic          op_wr;
  logic [AW-1:0] op_idx;
  logic          legal;
  logic          accept;
  logic          do_wr;

  // Per-op effect and legality from sp_op, wr_en and count only;
  // op_valid and clear gate whether anything actually commits.
  always_comb begin
    op_count = count_q;
    op_wr    = 1'b0;
    op_idx   = '0;
    legal    = 1'b1;
    case (sp_op)
      OP_ADV_1: begin
        legal    = (count_q != DEPTH_C);
        op_count = count_q + ONE;
        op_wr    = 1'b1;
        op_idx   = AW'(count_q);
      end
      OP_ADV_0: begin
        legal    = !wr_en || (count_q >= ONE);
        op_wr    = wr_en;
        op_idx   = AW'(count_q - ONE);
      end
      OP_DES_1: begin
        legal    = wr_en ? (count_q >= TWO) : (count_q >= ONE);
        op_count = count_q - ONE;
        op_wr    = wr_en;
        op_idx   = AW'(count_q - TWO);
      end
      default: begin
        legal    = (count_q >= TWO);
        op_count = count_q - TWO;
      end
    endcase
  end

  assign accept = op_valid && legal && !clear;
  assign do_wr  = accept && op_wr;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (accept) begin
      count_d = op_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Array is not reset; rst_n gating only keeps an edge during reset from writing.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) begin
      mem_q[op_idx] <= wr_data;
    end
  end

`ifdef OPERAND_STACK_GUARD_EN
  logic       err_q;
  logic [1:0] err_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else if (clear) begin
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else if (op_valid && !legal) begin
      err_q <= 1'b1;
      if (!err_q) begin
        err_code_q <= (sp_op == OP_ADV_1) ? 2'b01 : 2'b10;
      end
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
`else
  assign err      = 1'b0;
  assign err_code = 2'b00;
`endif

  logic [AW-1:0] top_idx, second_idx;
  assign top_idx    = AW'(count_q - ONE);
  assign second_idx = AW'(count_q - TWO);

  assign top    = (count_q >= ONE) ? mem_q[top_idx]    : '0;
  assign second = (count_q >= TWO) ? mem_q[second_idx] : '0;
  assign count  = count_q;
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);

endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - Self-checking bench for operand_stack (table, corner sequences, random vs queue model)
module tb_operand_stack;

  localparam int W = 8;
  localparam int D = 16;
`ifdef OPERAND_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [1:0] DES_2 = 2'b00;
  localparam logic [1:0] DES_1 = 2'b01;
  localparam logic [1:0] ADV_0 = 2'b10;
  localparam logic [1:0] ADV_1 = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         op_valid = 1'b0;
  logic [1:0]   sp_op = 2'b00;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] top, second;
  logic [4:0]   count;
  logic         full, empty, err;
  logic [1:0]   err_code;

  operand_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .op_valid(op_valid), .sp_op(sp_op),
    .wr_en(wr_en), .wr_data(wr_data), .top(top), .second(second), .count(count),
    .full(full), .empty(empty), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: the stack as a queue, back = top.
  logic [W-1:0] mq[$];
  bit           m_err;
  logic [1:0]   m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_err  = 1'b0;
    m_code = 2'b00;
  endtask

  task automatic model_op(input bit c, input bit v, input logic [1:0] op, input bit we, input logic [W-1:0] d);
    bit         bad;
    logic [1:0] why;
    bad = 1'b0;
    why = 2'b10;
    if (c) begin
      model_reset();
    end else if (v) begin
      case (op)
        ADV_1: if (mq.size() < D) mq.push_back(d); else begin bad = 1'b1; why = 2'b01; end
        ADV_0: if (we) begin
                 if (mq.size() >= 1) mq[mq.size()-1] = d; else bad = 1'b1;
               end
        DES_1: if (we) begin
                 if (mq.size() >= 2) begin void'(mq.pop_back()); mq[mq.size()-1] = d; end
                 else bad = 1'b1;
               end else begin
                 if (mq.size() >= 1) void'(mq.pop_back()); else bad = 1'b1;
               end
        default: if (mq.size() >= 2) begin void'(mq.pop_back()); void'(mq.pop_back()); end
                 else bad = 1'b1;
      endcase
      if (bad && GUARD) begin
        if (!m_err) m_code = why;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] et, es;
    int n;
    n  = mq.size();
    et = (n >= 1) ? mq[n-1] : '0;
    es = (n >= 2) ? mq[n-2] : '0;
    chk({tag, ".count"},    32'(count),    32'(n));
    chk({tag, ".top"},      32'(top),      32'(et));
    chk({tag, ".second"},   32'(second),   32'(es));
    chk({tag, ".full"},     32'(full),     32'(n == D));
    chk({tag, ".empty"},    32'(empty),    32'(n == 0));
    chk({tag, ".err"},      32'(err),      32'(m_err));
    chk({tag, ".err_code"}, 32'(err_code), 32'(m_code));
  endtask

  // Drive between edges, let one rising edge accept, then check #1 later.
  task automatic step(input string tag, input bit c, input bit v, input logic [1:0] op,
                      input bit we, input logic [W-1:0] d);
    clear = c; op_valid = v; sp_op = op; wr_en = we; wr_data = d;
    @(posedge clk);
    model_op(c, v, op, we, d);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit           c;
    bit           v;
    logic [1:0]   op;
    bit           we;
    logic [W-1:0] d;
    int           e_count;
    logic [W-1:0] e_top;
    logic [W-1:0] e_second;
    bit           e_err;
    logic [1:0]   e_code;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int thr;
    tbl[0]  = '{0, 1, ADV_1, 0, 8'h11, 1, 8'h11, 8'h00, 0, 2'b00};
    tbl[1]  = '{0, 1, ADV_1, 0, 8'h22, 2, 8'h22, 8'h11, 0, 2'b00};
    tbl[2]  = '{0, 1, ADV_1, 1, 8'h33, 3, 8'h33, 8'h22, 0, 2'b00};
    tbl[3]  = '{0, 0, ADV_1, 1, 8'h44, 3, 8'h33, 8'h22, 0, 2'b00};
    tbl[4]  = '{0, 1, ADV_0, 1, 8'h44, 3, 8'h44, 8'h22, 0, 2'b00};
    tbl[5]  = '{0, 1, ADV_0, 0, 8'h99, 3, 8'h44, 8'h22, 0, 2'b00};
    tbl[6]  = '{0, 1, DES_1, 0, 8'h99, 2, 8'h22, 8'h11, 0, 2'b00};
    tbl[7]  = '{0, 1, DES_2, 1, 8'h99, 0, 8'h00, 8'h00, 0, 2'b00};
    tbl[8]  = '{0, 1, ADV_1, 0, 8'h05, 1, 8'h05, 8'h00, 0, 2'b00};
    tbl[9]  = '{0, 1, ADV_1, 0, 8'h07, 2, 8'h07, 8'h05, 0, 2'b00};
    tbl[10] = '{0, 1, DES_1, 1, 8'h0C, 1, 8'h0C, 8'h00, 0, 2'b00};
    tbl[11] = '{0, 1, DES_1, 1, 8'h5A, 1, 8'h0C, 8'h00, 1, 2'b10};
    tbl[12] = '{1, 1, ADV_1, 0, 8'h66, 0, 8'h00, 8'h00, 0, 2'b00};
    tbl[13] = '{0, 1, ADV_1, 0, 8'hAA, 1, 8'hAA, 8'h00, 0, 2'b00};
    tbl[14] = '{0, 1, DES_2, 0, 8'h00, 1, 8'hAA, 8'h00, 1, 2'b10};
    tbl[15] = '{0, 1, ADV_1, 0, 8'hBB, 2, 8'hBB, 8'hAA, 1, 2'b10};
    tbl[16] = '{1, 0, ADV_1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 2'b00};

    model_reset();
    #12;
    chk("reset.count", 32'(count), 0);
    chk("reset.empty", 32'(empty), 1);
    chk("reset.full",  32'(full),  0);
    chk("reset.top",   32'(top),   0);
    chk("reset.err",   32'(err),   0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of ops with independently written expectations.
    for (int i = 0; i < 17; i++) begin
      string tg;
      tg = $sformatf("tbl%0d", i);
      step(tg, tbl[i].c, tbl[i].v, tbl[i].op, tbl[i].we, tbl[i].d);
      chk({tg, ".k_count"},  32'(count),  32'(tbl[i].e_count));
      chk({tg, ".k_top"},    32'(top),    32'(tbl[i].e_top));
      chk({tg, ".k_second"}, 32'(second), 32'(tbl[i].e_second));
      chk({tg, ".k_err"},    32'(err),    32'(GUARD ? tbl[i].e_err : 1'b0));
      chk({tg, ".k_code"},   32'(err_code), 32'(GUARD ? tbl[i].e_code : 2'b00));
    end

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < D; i++) step("fill", 0, 1, ADV_1, 0, 8'(i + 1));
    step("ovf", 0, 1, ADV_1, 1, 8'hFF);
    chk("ovf.k_full",  32'(full),  1);
    chk("ovf.k_count", 32'(count), 16);
    chk("ovf.k_top",   32'(top),   32'h10);
    chk("ovf.k_err",   32'(err),   32'(GUARD));
    chk("ovf.k_code",  32'(err_code), GUARD ? 32'h1 : 32'h0);

    // clear beats a same-cycle push.
    step("clr0", 1, 0, DES_2, 0, 8'h00);
    for (int i = 0; i < 4; i++) step("push4", 0, 1, ADV_1, 0, 8'(8'h40 + i));
    step("clr_push", 1, 1, ADV_1, 0, 8'hEE);
    chk("clr_push.k_count", 32'(count), 0);
    chk("clr_push.k_empty", 32'(empty), 1);
    chk("clr_push.k_err",   32'(err),   0);

    // clear beats a same-cycle illegal op.
    step("unf_empty", 0, 1, DES_2, 0, 8'h00);
    step("clr_unf", 1, 1, DES_2, 0, 8'h00);
    chk("clr_unf.k_err", 32'(err), 0);

    // Async reset in the middle of a push stream.
    step("pre_rst", 0, 1, ADV_1, 0, 8'h71);
    step("pre_rst", 0, 1, ADV_1, 0, 8'h72);
    clear = 0; op_valid = 1; sp_op = ADV_1; wr_data = 8'h73;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_model("rst_held");
    #3;
    rst_n = 1'b1;
    step("post_rst", 0, 1, ADV_1, 0, 8'h74);
    chk("post_rst.k_count", 32'(count), 1);
    chk("post_rst.k_top",   32'(top),   32'h74);

    // Random ops against the queue model, alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 2400; i++) begin
      logic [1:0] op;
      int x;
      thr = ((i / 200) % 2 == 0) ? 7 : 3;
      x = $urandom_range(0, 9);
      if (x < thr) op = ADV_1;
      else op = 2'($urandom_range(0, 2));
      step("rnd", $urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0, op,
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
